// File: rtl/paralelo_serie_cond.sv
// rtl/paralelo_serie_cond.sv - per-lane parallel-to-serial transmitter with comma preamble
module paralelo_serie_cond #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned SYNC_COMMAS = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       byte_req,
    output logic       data_out,
    output logic       sync_done
);

    localparam logic [3:0] SYNC_LAST = SYNC_COMMAS[3:0];

    typedef enum logic {
        ST_SYNC,
        ST_DATA
    } state_t;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [3:0] comma_cnt_q;
    logic       data_out_q;
    logic       byte_req_q;
    logic       sync_done_q;
    logic       data_rule;

    // The load at the coming boundary takes upstream data: already in DATA,
    // or the preamble has just sent its last comma.
    assign data_rule = (state_q == ST_DATA) || (comma_cnt_q == SYNC_LAST);

    always_comb begin
        shreg_d = {shreg_q[6:0], 1'b0};
        if (bit_cnt_q == 3'd7) begin
            shreg_d = (data_rule && valid_in) ? data_in : COMMA;
        end
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SYNC;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= COMMA;
            comma_cnt_q <= 4'd1;
            data_out_q  <= 1'b0;
            byte_req_q  <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            data_out_q <= shreg_q[7];
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            shreg_q    <= shreg_d;
            // Raised one cycle ahead so it is high exactly while bit_cnt==7.
            byte_req_q <= (bit_cnt_q == 3'd6) && data_rule;
            if ((bit_cnt_q == 3'd7) && (state_q == ST_SYNC)) begin
                if (comma_cnt_q == SYNC_LAST) begin
                    state_q     <= ST_DATA;
                    sync_done_q <= 1'b1;
                end else begin
                    comma_cnt_q <= comma_cnt_q + 4'd1;
                end
            end
        end
    end

    assign data_out  = data_out_q;
    assign byte_req  = byte_req_q;
    assign sync_done = sync_done_q;

endmodule

// File: tb/tb_paralelo_serie_cond.sv
// tb/tb_paralelo_serie_cond.sv - directed vector bench for paralelo_serie_cond
module tb_paralelo_serie_cond;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       byte_req;
    logic       data_out;
    logic       sync_done;

    logic       rst1;
    logic [7:0] d1;
    logic       v1;
    logic       br1;
    logic       do1;
    logic       sd1;

    always #5 clk_8f = ~clk_8f;

    paralelo_serie_cond dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .byte_req  (byte_req),
        .data_out  (data_out),
        .sync_done (sync_done)
    );

    paralelo_serie_cond #(.COMMA(8'hBC), .SYNC_COMMAS(1)) dut1 (
        .clk_8f    (clk_8f),
        .reset     (rst1),
        .data_in   (d1),
        .valid_in  (v1),
        .byte_req  (br1),
        .data_out  (do1),
        .sync_done (sd1)
    );

    typedef struct {
        logic [7:0] din;
        logic       vin;
        logic [7:0] exp;
        string      name;
    } vec_t;

    localparam int NV = 7;
    localparam int M  = 32 + 8 * NV;

    vec_t vecs[NV];

    logic bo [0:127];
    logic brr[0:127];
    logic sdr[0:127];
    logic bo1[0:127];
    logic br1r[0:127];
    logic sd1r[0:127];
    int   ecount;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_8f);
        #1;
        ecount++;
        bo[ecount]   = data_out;
        brr[ecount]  = byte_req;
        sdr[ecount]  = sync_done;
        bo1[ecount]  = do1;
        br1r[ecount] = br1;
        sd1r[ecount] = sd1;
    endtask

    function automatic logic [7:0] grab(input int s, input bit which);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = which ? bo1[s+i] : bo[s+i];
        return r;
    endfunction

    initial begin
        int errs;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, "a5"};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF, "ff_b2b"};
        vecs[2] = '{8'h00, 1'b1, 8'h00, "00_b2b"};
        vecs[3] = '{8'h3C, 1'b1, 8'h3C, "3c"};
        vecs[4] = '{8'hFF, 1'b0, 8'hBC, "invalid_comma"};
        vecs[5] = '{8'hC3, 1'b1, 8'hC3, "c3"};
        vecs[6] = '{8'hBC, 1'b1, 8'hBC, "data_eq_comma"};

        reset = 1'b0; rst1 = 1'b0;
        data_in = 8'h00; valid_in = 1'b0;
        d1 = 8'h00; v1 = 1'b0;
        ecount = 0;

        #32;
        chk("rst_data_out",  {31'd0, data_out},  32'd0);
        chk("rst_byte_req",  {31'd0, byte_req},  32'd0);
        chk("rst_sync_done", {31'd0, sync_done}, 32'd0);
        chk("rst1_data_out", {31'd0, do1},       32'd0);
        reset = 1'b1;

        for (int e = 1; e <= M; e++) begin
            if (e >= 32 && (e % 8) == 0 && ((e - 32) / 8) < NV) begin
                data_in  = vecs[(e-32)/8].din;
                valid_in = vecs[(e-32)/8].vin;
            end else begin
                data_in  = 8'hF7;
                valid_in = 1'b1;
            end
            tick();
        end

        for (int k = 0; k < 4; k++) chk($sformatf("preamble_byte%0d", k), {24'd0, grab(1 + 8*k, 1'b0)}, 32'hBC);
        chk("byte_req_e31", {31'd0, brr[31]}, 32'd1);
        chk("sync_done_e31", {31'd0, sdr[31]}, 32'd0);
        chk("sync_done_e32", {31'd0, sdr[32]}, 32'd1);
        errs = 0;
        for (int e = 1; e <= M; e++) begin
            if (brr[e] !== ((e % 8) == 7 && e >= 31)) errs++;
            if (sdr[e] !== (e >= 32)) errs++;
        end
        chk("req_sync_sweep", errs, 0);
        for (int j = 0; j < NV; j++) chk(vecs[j].name, {24'd0, grab(33 + 8*j, 1'b0)}, {24'd0, vecs[j].exp});

        // Reset pulse in the middle of a data byte (garbage 0xF7, bit4 = 1)
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_bit4", {31'd0, data_out}, 32'd1);
        chk("pre_rst_sync", {31'd0, sync_done}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_data_out",  {31'd0, data_out},  32'd0);
        chk("async_rst_byte_req",  {31'd0, byte_req},  32'd0);
        chk("async_rst_sync_done", {31'd0, sync_done}, 32'd0);
        #2;
        data_in = 8'hFF; valid_in = 1'b0;
        reset = 1'b1; rst1 = 1'b1;
        ecount = 0;

        for (int e = 1; e <= 32; e++) begin
            if (e == 8) begin d1 = 8'h81; v1 = 1'b1; end
            else begin d1 = 8'hF7; v1 = 1'b1; end
            tick();
        end

        for (int k = 0; k < 4; k++) chk($sformatf("re_preamble_byte%0d", k), {24'd0, grab(1 + 8*k, 1'b0)}, 32'hBC);
        errs = 0;
        for (int e = 1; e <= 32; e++) begin
            if (brr[e] !== (e == 31)) errs++;
            if (sdr[e] !== (e == 32)) errs++;
        end
        chk("re_req_sync_sweep", errs, 0);

        chk("sc1_comma", {24'd0, grab(1, 1'b1)}, 32'hBC);
        chk("sc1_data81", {24'd0, grab(9, 1'b1)}, 32'h81);
        chk("sc1_req_e7", {31'd0, br1r[7]}, 32'd1);
        chk("sc1_sync_e7", {31'd0, sd1r[7]}, 32'd0);
        chk("sc1_sync_e8", {31'd0, sd1r[8]}, 32'd1);
        errs = 0;
        for (int e = 1; e <= 32; e++) if (br1r[e] !== ((e % 8) == 7)) errs++;
        chk("sc1_req_sweep", errs, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
